led_arbiter: RTL
================

// Module: led_arbiter
// PURPOSE
//  Time-slices the 12-LED bicolour display between NREQ requesters (demo patterns,
//  debug status, UART activity). Each requester supplies a yr/bg frame; a round-robin
//  arbiter grants one owner at a time and registers its frame into led_yr/led_bg.
//  Sits directly upstream of led_ctrl (led_yr->led_in_yr, led_bg->led_in_bg) in top.
// PARAMETERS
//  NREQ      4          number of requesters, 2..8
//  W         12         LED count / frame width
//  SLICE_CYC 1200000    cycles per time slice (100 ms at 12 MHz), >=2
// PORTS
//  clk     in   1        system clock (12 MHz board clock)
//  rst     in   1        synchronous reset, active-high
//  req     in   NREQ     request lines; req[i] held high while requester i wants display
//  yr_in   in   NREQ*W   yellow/red frames; requester i at [i*W +: W]
//  bg_in   in   NREQ*W   blue/green frames; requester i at [i*W +: W]
//  grant   out  NREQ     one-hot current owner, all-zero when idle
//  owner   out  3        binary index of owner (0 when idle)
//  busy    out  1        high while any grant active
//  led_yr  out  W        registered yr frame of owner, 0 when idle
//  led_bg  out  W        registered bg frame of owner, 0 when idle
// BEHAVIOUR
//  - Reset: grant=0, owner=0, busy=0, led_yr=led_bg=0, rr pointer=0, slice ctr=0.
//    Reset mid-slice aborts immediately; no frame is held over.
//  - States: IDLE (grant=0), HOLD (one owner). All outputs registered.
//  - IDLE->HOLD: at any edge with req!=0, grant first set bit of req scanning from rr
//    pointer upward (wrap NREQ-1 -> 0); slice ctr <= SLICE_CYC-1. Grant visible one
//    cycle after req seen.
//  - Data path: every edge in HOLD (including the granting edge) led_yr/led_bg <=
//    yr_in/bg_in of the new/current owner: 1-cycle latency from input to LED port.
//  - HOLD, slice ctr decrements by 1 per cycle, saturates at 0.
//  - Release (owner req low at edge): hand off at that same edge to next pending
//    requester after owner (RR); if none pending -> IDLE, grant=0, outputs 0. No gap cycle.
//  - Expiry (ctr==0, owner still requesting): if another req pending, hand off to next
//    after owner, reload ctr; else owner keeps grant, ctr reloads to SLICE_CYC-1.
//  - Release and expiry on same edge: release rule applies (identical RR target).
//  - rr pointer <= owner+1 (mod NREQ) on every grant change; fairness: any requester
//    held high is granted within (NREQ-1)*SLICE_CYC+1 cycles.
//  - Inputs on non-owned slots ignored; grant never has >1 bit set.
// CONFIGURATION
//  LED_ARB_PRIO_EN defined: req[0] is a priority requester. If req[0] high while
//    another index owns, grant moves to 0 at next edge regardless of slice ctr; while
//    0 owns, expiry is ignored (holds until req[0] drops, then RR from index 1).
//  LED_ARB_PRIO_EN undefined: req[0] is an ordinary round-robin requester.
// TESTING  (NREQ=4, W=12, SLICE_CYC=8)
//  1 rst=1 two cycles with req=4'hF -> grant=0, owner=0, busy=0, led_yr=led_bg=0.
//  2 req=4'b0100, yr_in[2]=12'hABC, bg_in[2]=12'h123 -> grant=4'b0100, owner=2 next
//    cycle; led_yr=12'hABC, led_bg=12'h123 same cycle; change yr_in[2]->12'h555, LED
//    follows 1 cycle later.
//  3 req=4'b0011 held -> grant 0001 for 8 cycles, 0010 for 8, alternating forever.
//  4 owner 1 drops req with req[3] pending -> grant=4'b1000 next edge; then req[3]
//    drops with none pending -> grant=0, led_yr=led_bg=0, busy=0 next edge.
//  5 owner 2 drops req on exact expiry cycle, req=4'b1011 -> next owner 3, then 0, 1.
//  6 owner 2 mid-slice, assert req[0]: with LED_ARB_PRIO_EN grant=4'b0001 next edge
//    and held past 8 cycles; without it grant changes only at slice end.

Source files
------------

// File: rtl/led_arbiter_if.sv
// Bundles the requester frames/requests and the arbiter's grant and LED outputs.
// master = requester/top side, slave = arbiter side.
interface led_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 12
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] yr_in;
    logic [NREQ*W-1:0] bg_in;
    logic [NREQ-1:0]   grant;
    logic [2:0]        owner;
    logic              busy;
    logic [W-1:0]      led_yr;
    logic [W-1:0]      led_bg;

    modport master (
        output req, yr_in, bg_in,
        input  grant, owner, busy, led_yr, led_bg
    );

    modport slave (
        input  req, yr_in, bg_in,
        output grant, owner, busy, led_yr, led_bg
    );
endinterface

// File: rtl/led_arbiter.sv
// Round-robin time-slice arbiter for the bicolour LED frame; all outputs registered, 1-cycle latency.
// Optional macro LED_ARB_PRIO_EN makes requester 0 a pre-empting priority requester.
module led_arbiter #(
    parameter int NREQ      = 4,
    parameter int W         = 12,
    parameter int SLICE_CYC = 1200000
) (
    input  logic          clk,
    input  logic          rst,
    led_arbiter_if.slave  bus
);
    localparam int CW = $clog2(SLICE_CYC);
    localparam logic [CW-1:0] RELOAD = CW'(SLICE_CYC - 1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e          state_q, state_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      rr_q, rr_d;
    logic [CW-1:0]   ctr_q, ctr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [W-1:0]    yr_q, yr_d;
    logic [W-1:0]    bg_q, bg_d;

    // Returns {found, index}: first set request scanning span slots upward from start.
    function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] r,
                                           input logic [2:0] start,
                                           input int span);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(start) + i) % NREQ;
            if (!res[3] && i < span && r[idx])
                res = {1'b1, 3'(idx)};
        end
        return res;
    endfunction

    logic [3:0] pick;
    logic [2:0] after_owner;
    logic       switch_en;
    logic [2:0] tgt;
    logic       expire;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        ctr_d       = ctr_q;
        switch_en   = 1'b0;
        tgt         = '0;
        expire      = 1'b0;
        after_owner = 3'((int'(owner_q) + 1) % NREQ);
        pick        = '0;

        case (state_q)
            IDLE: begin
                pick = rr_pick(bus.req, rr_q, NREQ);
`ifdef LED_ARB_PRIO_EN
                if (bus.req[0])
                    pick = 4'b1000;
`endif
                switch_en = pick[3];
                tgt       = pick[2:0];
            end
            HOLD: begin
                // Scan the other requesters only; on release the owner's own bit is low anyway.
                pick   = rr_pick(bus.req, after_owner, NREQ - 1);
                expire = (ctr_q == '0);
`ifdef LED_ARB_PRIO_EN
                if (owner_q == '0)
                    expire = 1'b0;
                if (owner_q != '0 && bus.req[0]) begin
                    switch_en = 1'b1;
                    tgt       = '0;
                end else
`endif
                if (!bus.req[owner_q]) begin
                    if (pick[3]) begin
                        switch_en = 1'b1;
                        tgt       = pick[2:0];
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                    end
                end else if (expire) begin
                    if (pick[3]) begin
                        switch_en = 1'b1;
                        tgt       = pick[2:0];
                    end else begin
                        ctr_d = RELOAD;
                    end
                end else if (ctr_q != '0) begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase

        if (switch_en) begin
            state_d = HOLD;
            owner_d = tgt;
            rr_d    = 3'((int'(tgt) + 1) % NREQ);
            ctr_d   = RELOAD;
        end

        grant_d = '0;
        yr_d    = '0;
        bg_d    = '0;
        if (state_d == HOLD) begin
            for (int i = 0; i < NREQ; i++)
                grant_d[i] = (owner_d == 3'(i));
            yr_d = bus.yr_in[int'(owner_d)*W +: W];
            bg_d = bus.bg_in[int'(owner_d)*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            ctr_q   <= '0;
            grant_q <= '0;
            yr_q    <= '0;
            bg_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            ctr_q   <= ctr_d;
            grant_q <= grant_d;
            yr_q    <= yr_d;
            bg_q    <= bg_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = (state_q == HOLD);
    assign bus.led_yr = yr_q;
    assign bus.led_bg = bg_q;
endmodule
